// File: rtl/snd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : snd_pkg
// Purpose  : Shared types and constants for the sound-ROM sequencer.
// Revision : 1.0
// ============================================================================
package snd_pkg;

  localparam int SND_ADDR_W = 9;
  localparam int SND_DATA_W = 10;

  localparam logic [SND_DATA_W-1:0] SND_MARK_LO = 10'd0;
  localparam logic [SND_DATA_W-1:0] SND_MARK_HI = 10'd1023;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_LOAD  = 2'd2,
    ST_COUNT = 2'd3
  } snd_state_e;

  function automatic logic snd_is_marker(input logic [SND_DATA_W-1:0] d);
    return (d == SND_MARK_LO) || (d == SND_MARK_HI);
  endfunction

endpackage
`default_nettype wire

// File: rtl/snd_tick_div.sv
`default_nettype none
// ============================================================================
// Module   : snd_tick_div
// Purpose  : Prescaler producing one tick every TICK_DIV cycles while clr low.
// Revision : 1.0
// ============================================================================
module snd_tick_div #(
  parameter int TICK_DIV = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = !clr && (cnt_q == CNT_LAST);
    cnt_d = cnt_q + 1'b1;
    if (clr || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pacman_sound_seq.sv
`default_nettype none
// ============================================================================
// Module   : pacman_sound_seq
// Purpose  : Walks a sound ROM of half-period durations, toggling a square
//            wave. Define SND_PENDING_EN to queue one replay on start-while-busy.
// Revision : 1.0
// ============================================================================
module pacman_sound_seq
  import snd_pkg::*;
#(
  parameter int START_ADDR = 1,
  parameter int END_ADDR   = 417,
  parameter int TICK_DIV   = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  output logic [SND_ADDR_W-1:0] rom_addr,
  input  logic [SND_DATA_W-1:0] rom_data,
  output logic                  audio,
  output logic                  busy
);

  localparam logic [SND_ADDR_W-1:0] START_A = SND_ADDR_W'(START_ADDR);
  localparam logic [SND_ADDR_W-1:0] END_A   = SND_ADDR_W'(END_ADDR);

  snd_state_e            state_q, state_d;
  logic [SND_ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [SND_DATA_W-1:0] dur_cnt_q, dur_cnt_d;
  logic                  audio_q, audio_d;
  logic                  seq_end;
  logic                  tick;
  logic                  pend_req;

  snd_tick_div #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_q != ST_COUNT),
    .tick (tick)
  );

`ifdef SND_PENDING_EN
  logic pending_q, pending_d;

  // A start arriving on the very cycle the pass ends still counts as a replay.
  assign pend_req = pending_q | start;

  always_comb begin
    pending_d = pending_q;
    if (busy && start) pending_d = 1'b1;
    if (seq_end || stop) pending_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending_q <= 1'b0;
    else     pending_q <= pending_d;
  end
`else
  assign pend_req = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    dur_cnt_d  = dur_cnt_q;
    audio_d    = audio_q;
    seq_end    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        rom_addr_d = START_A;
        audio_d    = 1'b0;
        if (start) state_d = ST_FETCH;
      end
      ST_FETCH: state_d = ST_LOAD;
      ST_LOAD: begin
        if (snd_is_marker(rom_data)) begin
          seq_end = 1'b1;
        end else begin
          dur_cnt_d = rom_data;
          audio_d   = ~audio_q;
          state_d   = ST_COUNT;
        end
      end
      ST_COUNT: begin
        if (tick) begin
          dur_cnt_d = dur_cnt_q - 1'b1;
          if (dur_cnt_q == 10'd1) begin
            if (rom_addr_q == END_A) begin
              seq_end = 1'b1;
            end else begin
              rom_addr_d = rom_addr_q + 1'b1;
              state_d    = ST_FETCH;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (seq_end) begin
      audio_d = 1'b0;
      if (pend_req) begin
        state_d    = ST_FETCH;
        rom_addr_d = START_A;
      end else begin
        state_d = ST_IDLE;
      end
    end

    if (stop) begin
      state_d    = ST_IDLE;
      audio_d    = 1'b0;
      rom_addr_d = START_A;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rom_addr_q <= START_A;
      dur_cnt_q  <= '0;
      audio_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      dur_cnt_q  <= dur_cnt_d;
      audio_q    <= audio_d;
    end
  end

  assign rom_addr = rom_addr_q;
  assign audio    = audio_q;
  assign busy     = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_pacman_sound_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_pacman_sound_seq
// Purpose  : Self-checking bench; expected busy/audio traces are built from
//            the ROM contents by a segment-level model.
// Revision : 1.0
// ============================================================================
module tb_pacman_sound_seq;

  localparam int TD = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_a, stop_a, start_b, stop_b;
  logic [8:0] addr_a, addr_b;
  logic [9:0] rd_a, rd_b;
  logic       audio_a, busy_a, audio_b, busy_b;

  logic [9:0] rom [0:511];
  logic [1:0] exp_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rd_a <= rom[addr_a];
    rd_b <= rom[addr_b];
  end

  pacman_sound_seq #(.START_ADDR(1), .END_ADDR(417), .TICK_DIV(TD)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .stop(stop_a),
    .rom_addr(addr_a), .rom_data(rd_a), .audio(audio_a), .busy(busy_a));

  pacman_sound_seq #(.START_ADDR(1), .END_ADDR(2), .TICK_DIV(TD)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .stop(stop_b),
    .rom_addr(addr_b), .rom_data(rd_b), .audio(audio_b), .busy(busy_b));

  task automatic rom_clear();
    for (int k = 0; k < 512; k++) rom[k] = 10'd0;
  endtask

  // One pass as {busy,audio} per cycle, starting at the FETCH cycle.
  task automatic model_pass(input int end_addr);
    int   addr;
    int   d;
    logic lvl;
    exp_q.push_back(2'b10);
    exp_q.push_back(2'b10);
    addr = 1;
    lvl  = 1'b0;
    while (addr < 512) begin
      d = int'(rom[addr]);
      if (d == 0 || d == 1023) break;
      lvl = ~lvl;
      if (addr == end_addr) begin
        repeat (d * TD) exp_q.push_back({1'b1, lvl});
        break;
      end
      repeat (d * TD + 2) exp_q.push_back({1'b1, lvl});
      addr++;
    end
  endtask

  task automatic model_idle_tail();
    repeat (3) exp_q.push_back(2'b00);
  endtask

  task automatic test_reset();
    rst = 1'b1; start_a = 0; stop_a = 0; start_b = 0; stop_b = 0;
    rom_clear();
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({busy_a, audio_a, addr_a} !== {2'b00, 9'd1}) begin
      n_bad++;
      $display("FAIL reset_a: got busy/audio/addr=%b/%b/%0d want 0/0/1", busy_a, audio_a, addr_a);
    end
    n_cmp++;
    if ({busy_b, audio_b, addr_b} !== {2'b00, 9'd1}) begin
      n_bad++;
      $display("FAIL reset_b: got busy/audio/addr=%b/%b/%0d want 0/0/1", busy_b, audio_b, addr_b);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_marker_play();
    rom_clear();
    rom[1] = 10'd3; rom[2] = 10'd2; rom[3] = 10'd0;
    exp_q.delete();
    model_pass(417);
    model_idle_tail();
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if ({busy_a, audio_a} !== exp_q[i]) begin
        n_bad++;
        $display("FAIL marker_play cyc %0d: got busy/audio=%b want %b", i, {busy_a, audio_a}, exp_q[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_end_addr();
    rom_clear();
    rom[1] = 10'd1; rom[2] = 10'd1; rom[3] = 10'd5; rom[4] = 10'd5;
    exp_q.delete();
    model_pass(2);
    model_idle_tail();
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if ({busy_b, audio_b} !== exp_q[i]) begin
        n_bad++;
        $display("FAIL end_addr cyc %0d: got busy/audio=%b want %b", i, {busy_b, audio_b}, exp_q[i]);
      end
      n_cmp++;
      if (addr_b > 9'd2) begin
        n_bad++;
        $display("FAIL end_addr_range cyc %0d: got rom_addr=%0d want <=2", i, addr_b);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_stop();
    rom_clear();
    rom[1] = 10'd3; rom[2] = 10'd2; rom[3] = 10'd1023;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++;
    if (audio_a !== 1'b1) begin
      n_bad++;
      $display("FAIL stop_pre: got audio=%b want 1", audio_a);
    end
    stop_a = 1'b1;
    @(negedge clk);
    stop_a = 1'b0;
    n_cmp++;
    if ({busy_a, audio_a, addr_a} !== {2'b00, 9'd1}) begin
      n_bad++;
      $display("FAIL stop_post: got busy/audio/addr=%b/%b/%0d want 0/0/1", busy_a, audio_a, addr_a);
    end
    repeat (2) @(negedge clk);
    exp_q.delete();
    model_pass(417);
    model_idle_tail();
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if ({busy_a, audio_a} !== exp_q[i]) begin
        n_bad++;
        $display("FAIL stop_replay cyc %0d: got busy/audio=%b want %b", i, {busy_a, audio_a}, exp_q[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_pending();
    rom_clear();
    rom[1] = 10'd3; rom[2] = 10'd2; rom[3] = 10'd0;
    exp_q.delete();
    model_pass(417);
`ifdef SND_PENDING_EN
    model_pass(417);
`endif
    model_idle_tail();
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if ({busy_a, audio_a} !== exp_q[i]) begin
        n_bad++;
        $display("FAIL pending cyc %0d: got busy/audio=%b want %b", i, {busy_a, audio_a}, exp_q[i]);
      end
      start_a = (i == 3 || i == 6 || i == 9);
      @(negedge clk);
    end
    start_a = 1'b0;
  endtask

  task automatic test_start_stop_same();
    start_a = 1'b1;
    stop_a  = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    stop_a  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (busy_a !== 1'b0) begin
        n_bad++;
        $display("FAIL start_stop_same cyc %0d: got busy=%b want 0", i, busy_a);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_async_reset();
    rom_clear();
    rom[1] = 10'd4; rom[2] = 10'd0;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({busy_a, audio_a, addr_a} !== {2'b00, 9'd1}) begin
      n_bad++;
      $display("FAIL async_reset: got busy/audio/addr=%b/%b/%0d want 0/0/1", busy_a, audio_a, addr_a);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      int n;
      rom_clear();
      n = int'($urandom_range(1, 4));
      for (int k = 1; k <= n; k++) rom[k] = 10'($urandom_range(1, 6));
      rom[n + 1] = ($urandom_range(0, 1) == 0) ? 10'd0 : 10'd1023;
      exp_q.delete();
      model_pass(417);
      model_idle_tail();
      repeat ($urandom_range(0, 3)) @(negedge clk);
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      for (int i = 0; i < exp_q.size(); i++) begin
        n_cmp++;
        if ({busy_a, audio_a} !== exp_q[i]) begin
          n_bad++;
          $display("FAIL random it %0d cyc %0d: got busy/audio=%b want %b", it, i, {busy_a, audio_a}, exp_q[i]);
        end
        @(negedge clk);
      end
    end
  endtask

  initial begin
    test_reset();
    test_marker_play();
    test_end_addr();
    test_stop();
    test_pending();
    test_start_stop_same();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pacman_sound_seq.md
# pacman_sound_seq

Sequencer that plays an effect stored in a sound ROM such as the "wakka" table. The ROM holds 10-bit half-period durations. The block walks the ROM addresses, holds each duration for that many prescaler ticks, and toggles a 1-bit square-wave audio output between entries. It sits between the game logic (start/stop requests) and the ROM, and drives the speaker/PWM pin directly.

## Interface
- `START_ADDR`, default 1: first ROM address played. Address 0 holds a marker and is skipped.
- `END_ADDR`, default 417: last address played. Playback ends after this entry even without a marker.
- `TICK_DIV`, default 1000: clk cycles per duration unit (20 µs at 50 MHz). Must be ≥1.
- `clk` in, 1: system clock, rising edge.
- `rst` in, 1: asynchronous, active-high reset.
- `start` in, 1: single-cycle play request.
- `stop` in, 1: abort; has priority over `start`.
- `rom_addr` out, 9: ROM address. The ROM registers `rom_data` one cycle after `rom_addr`.
- `rom_data` in, 10: duration value from the ROM.
- `audio` out, 1: square-wave output.
- `busy` out, 1: high from the cycle after an accepted `start` until return to IDLE.

## Operation
- **Reset values:** state = IDLE, `audio` = 0, `busy` = 0, `rom_addr` = `START_ADDR`, pending = 0, counters = 0.
- **States:** IDLE, FETCH, LOAD, COUNT.
- **IDLE:**
  - `start` → FETCH.
  - `rom_addr` ← `START_ADDR`, `audio` ← 0.
- **FETCH:** one wait cycle for the ROM register. Always → LOAD.
- **LOAD:** samples `rom_data`.
  - If `rom_data` is a marker (0 or 1023): go to IDLE, or restart (see below); `audio` ← 0.
  - Otherwise: `dur_cnt` ← `rom_data`, tick counter ← 0, `audio` ← ~`audio`, → COUNT.
- **COUNT:**
  - The tick counter counts 0..`TICK_DIV`-1. Its wrap is one tick.
  - Each tick decrements `dur_cnt`.
  - On the tick where `dur_cnt` == 1:
    - If `rom_addr` == `END_ADDR`: end, same handling as a marker.
    - Otherwise: `rom_addr` += 1, → FETCH.
- **End of sound:** if pending = 1, clear pending and restart from `START_ADDR` via FETCH, with `busy` held high and `audio` = 0 for that cycle. Otherwise go to IDLE.
- **`stop`:** in any state, the next state is IDLE. `audio` ← 0, pending ← 0, `rom_addr` ← `START_ADDR`.
- **`start` while busy:** handled per the Configuration section.
- **`start` and `stop` in the same cycle:** `stop` wins, and the start is dropped.
- **Arithmetic:**
  - `dur_cnt` is 10-bit unsigned.
  - The tick counter is $clog2(`TICK_DIV`) bits wide, minimum 1.
  - No overflow is possible: 1022 × `TICK_DIV` cycles is the maximum segment length.

## Timing
- `start` sampled in cycle t → `busy` = 1 at t+1 (FETCH).
- LOAD is at t+2. `audio` first goes high at t+3.
- A segment with value d lasts exactly d·`TICK_DIV` + 2 cycles (COUNT plus FETCH plus LOAD). Each `audio` level therefore lasts d·`TICK_DIV` + 2 cycles.
- `rom_addr` changes only in IDLE, on the COUNT exit cycle, or on restart. It is stable through FETCH and LOAD.
- `stop` at cycle t → `audio` = 0 and `busy` = 0 at t+1.
- A marker or end at LOAD in cycle t → `busy` = 0 at t+1 when nothing is pending.

## Configuration
- **`SND_PENDING_EN` defined:**
  - `start` during `busy` sets a one-deep pending flag. Extra starts coalesce into that one flag.
  - The sound replays once immediately after the current pass ends, giving a continuous "wakka" while dots are eaten.
- **`SND_PENDING_EN` undefined:**
  - `start` during `busy` is ignored.
  - The pending register and restart path are removed. End always goes to IDLE.

## Structure
- **Package `snd_pkg`:**
  - state enum typedef.
  - `SND_MARK_LO` = 10'd0 and `SND_MARK_HI` = 10'd1023.
  - `SND_ADDR_W` = 9 and `SND_DATA_W` = 10.
- **Sub-module `snd_tick_div`:**
  - Parameterised `TICK_DIV` prescaler.
  - Inputs `clk`, `rst`, `clr`; output `tick`.
  - Cleared at LOAD; runs only in COUNT.

## Test plan
Bench uses `TICK_DIV` = 2 and a model ROM with 1-cycle read latency.
1. ROM [1]=3, [2]=2, [3]=0; pulse `start` → `audio` high for 8 cycles, then low for 6, then 0; `busy` drops 1 cycle after the LOAD of address 3.
2. No marker, `END_ADDR` = 2, ROM [1]=1, [2]=1 → two segments of 4 cycles each, then IDLE; `rom_addr` never exceeds 2.
3. `stop` asserted mid-COUNT of the first segment → next cycle `audio` = 0, `busy` = 0, `rom_addr` = 1; a new `start` then replays from address 1.
4. `SND_PENDING_EN` defined, three starts during playback → exactly one replay follows, then IDLE. `SND_PENDING_EN` undefined, same stimulus → no replay.
5. `start` and `stop` in the same cycle from IDLE → `busy` stays 0.
6. `rst` asserted asynchronously mid-COUNT → outputs take their reset values immediately, without waiting for a clock edge.
